// File: rtl/ex_mdu_pkg.sv
// ex_mdu_pkg: shared encodings for the execute stage and its iterative divider.
//   - aluop / alusel encodings (EXE_*_OP, EXE_RES_*)
//   - divider FSM state type
//   - reset level (RstEnable)
package ex_mdu_pkg;

    localparam logic RstEnable = 1'b0;

    // aluop encodings
    localparam logic [7:0] EXE_NOP_OP  = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP  = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP   = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP  = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP  = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP  = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP  = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP  = 8'b0000_0011;
    localparam logic [7:0] EXE_ADD_OP  = 8'b0010_0000;
    localparam logic [7:0] EXE_ADDU_OP = 8'b0010_0001;
    localparam logic [7:0] EXE_SUB_OP  = 8'b0010_0010;
    localparam logic [7:0] EXE_SUBU_OP = 8'b0010_0011;
    localparam logic [7:0] EXE_SLT_OP  = 8'b0010_1010;
    localparam logic [7:0] EXE_SLTU_OP = 8'b0010_1011;
    localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
    localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

    // alusel encodings
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;
    localparam logic [2:0] EXE_RES_ARITH = 3'b100;
    localparam logic [2:0] EXE_RES_DIV   = 3'b110;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'b00,
        DIV_BUSY = 2'b01,
        DIV_DONE = 2'b10
    } div_state_e;

endpackage

// File: rtl/ex_mdu_div_iter.sv
// div_iter: iterative radix-2 restoring divider, one quotient bit per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   DIV_IDLE | waiting; start latches |A|, |B| and the result signs
//   DIV_BUSY | one restoring step per cycle, WIDTH steps in total
//   DIV_DONE | quotient/remainder valid for exactly one cycle
//
// Ports:
//   clk, rst (sync, active low), start (DIV/DIVU present), signed_div,
//   flush (abort, back to IDLE), dividend, divisor,
//   busy (stall request), done (result strobe), quotient, remainder.
import ex_mdu_pkg::*;

module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_div,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(WIDTH);

    div_state_e       state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dvs_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic             neg_quo_q;
    logic             neg_rem_q;

    logic [WIDTH:0]   partial;
    logic [WIDTH:0]   trial;
    logic             qbit;
    logic [WIDTH-1:0] rem_step;
    logic [WIDTH-1:0] quo_step;
    logic [WIDTH-1:0] a_abs;
    logic [WIDTH-1:0] b_abs;

    always_comb begin
        partial  = {rem_q, dvd_q[WIDTH-1]};
        trial    = partial - {1'b0, dvs_q};
        qbit     = ~trial[WIDTH];
        // partial < 2*divisor, so when the trial borrows it already fits in WIDTH bits
        rem_step = qbit ? trial[WIDTH-1:0] : partial[WIDTH-1:0];
        quo_step = {quo_q[WIDTH-2:0], qbit};
        a_abs    = (signed_div && dividend[WIDTH-1]) ? -dividend : dividend;
        b_abs    = (signed_div && divisor[WIDTH-1])  ? -divisor  : divisor;
    end

    always_comb begin
        busy      = ~flush & (((state_q == DIV_IDLE) & start) | (state_q == DIV_BUSY));
        done      = ~flush & (state_q == DIV_DONE);
        quotient  = done ? quo_q : '0;
        remainder = done ? rem_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            dvd_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (flush) begin
            state_q <= DIV_IDLE;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        neg_quo_q <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                        neg_rem_q <= signed_div & dividend[WIDTH-1];
                        dvd_q     <= a_abs;
                        dvs_q     <= b_abs;
                        rem_q     <= '0;
                        quo_q     <= '0;
                        cnt_q     <= '0;
                        state_q   <= (divisor == '0) ? DIV_DONE : DIV_BUSY;
                    end
                end
                DIV_BUSY: begin
                    dvd_q <= dvd_q << 1;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) begin
                        // Sign fix-up folded into the last step so DONE just presents registers.
                        quo_q   <= neg_quo_q ? -quo_step : quo_step;
                        rem_q   <= neg_rem_q ? -rem_step : rem_step;
                        state_q <= DIV_DONE;
                    end else begin
                        quo_q <= quo_step;
                        rem_q <= rem_step;
                    end
                end
                DIV_DONE: state_q <= DIV_IDLE;
                default:  state_q <= DIV_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ex_mdu.sv
// ex_mdu: execute stage between id_ex and ex_mem.
//   Single-cycle logic / shift / arithmetic results; DIV/DIVU via div_iter
//   with a pipeline stall until HI/LO are ready.
// Ports:
//   clk, rst (sync, active low; forces every output to 0 while low)
//   aluop_i, alusel_i   operation and result class
//   reg1_i, reg2_i      operands (reg2_i low bits are the shift amount)
//   wd_i, wreg_i        destination passthrough -> wd_o, wreg_o
//   flush_i             aborts an in-flight divide
//   wdata_o             GPR write data
//   whilo_o, hi_o, lo_o HI/LO strobe, remainder, quotient
//   ovf_o               signed overflow on ADD/SUB (exception request)
//   stallreq_o          hold request to the pipeline controller
import ex_mdu_pkg::*;

module ex_mdu #(
    parameter int WIDTH      = 32,
    parameter int REG_ADDR_W = 5,
    parameter int AOP_W      = 8,
    parameter int ASEL_W     = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AOP_W-1:0]      aluop_i,
    input  logic [ASEL_W-1:0]     alusel_i,
    input  logic [WIDTH-1:0]      reg1_i,
    input  logic [WIDTH-1:0]      reg2_i,
    input  logic [REG_ADDR_W-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic                  flush_i,
    output logic [REG_ADDR_W-1:0] wd_o,
    output logic                  wreg_o,
    output logic [WIDTH-1:0]      wdata_o,
    output logic                  whilo_o,
    output logic [WIDTH-1:0]      hi_o,
    output logic [WIDTH-1:0]      lo_o,
    output logic                  ovf_o,
    output logic                  stallreq_o
);

    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;

    logic             active;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] res;
    logic             ovf;
    logic             div_start;
    logic             div_signed;
    logic             div_busy;
    logic             div_done;
    logic [WIDTH-1:0] div_quo;
    logic [WIDTH-1:0] div_rem;

    assign active = (rst != RstEnable);
    assign shamt  = reg2_i[SHW-1:0];
    assign sum    = reg1_i + reg2_i;
    assign diff   = reg1_i - reg2_i;

    always_comb begin
        res = '0;
        ovf = 1'b0;
        case (alusel_i)
            EXE_RES_LOGIC: begin
                case (aluop_i)
                    EXE_OR_OP:  res = reg1_i | reg2_i;
                    EXE_AND_OP: res = reg1_i & reg2_i;
                    EXE_XOR_OP: res = reg1_i ^ reg2_i;
                    EXE_NOR_OP: res = ~(reg1_i | reg2_i);
                    default:    res = '0;
                endcase
            end
            EXE_RES_SHIFT: begin
                case (aluop_i)
                    EXE_SLL_OP: res = reg1_i << shamt;
                    EXE_SRL_OP: res = reg1_i >> shamt;
                    EXE_SRA_OP: res = $signed(reg1_i) >>> shamt;
                    default:    res = '0;
                endcase
            end
            EXE_RES_ARITH: begin
                case (aluop_i)
                    EXE_ADD_OP: begin
                        res = sum;
                        ovf = (reg1_i[MSB] == reg2_i[MSB]) && (sum[MSB] != reg1_i[MSB]);
                    end
                    EXE_ADDU_OP: res = sum;
                    EXE_SUB_OP: begin
                        res = diff;
                        ovf = (reg1_i[MSB] != reg2_i[MSB]) && (diff[MSB] != reg1_i[MSB]);
                    end
                    EXE_SUBU_OP: res = diff;
                    EXE_SLT_OP:  res = {{(WIDTH-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                    EXE_SLTU_OP: res = {{(WIDTH-1){1'b0}}, (reg1_i < reg2_i)};
                    default:     res = '0;
                endcase
            end
            default: begin
                res = '0;
                ovf = 1'b0;
            end
        endcase
    end

    assign div_start  = (alusel_i == EXE_RES_DIV) &&
                        ((aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP));
    assign div_signed = (aluop_i == EXE_DIV_OP);

    div_iter #(.WIDTH(WIDTH)) u_div (
        .clk        (clk),
        .rst        (rst),
        .start      (div_start),
        .signed_div (div_signed),
        .flush      (flush_i),
        .dividend   (reg1_i),
        .divisor    (reg2_i),
        .busy       (div_busy),
        .done       (div_done),
        .quotient   (div_quo),
        .remainder  (div_rem)
    );

    // Reset gates the combinational paths too, so nothing leaks out while rst is low.
    assign wd_o       = active ? wd_i : '0;
    assign wreg_o     = active & wreg_i & ~ovf;
    assign ovf_o      = active & ovf;
    assign wdata_o    = (active && !div_done) ? res : '0;
    assign whilo_o    = active & div_done;
    assign hi_o       = active ? div_rem : '0;
    assign lo_o       = active ? div_quo : '0;
    assign stallreq_o = active & div_busy;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu (WIDTH=32).
import ex_mdu_pkg::*;

module tb_ex_mdu;

    logic        clk;
    logic        rst;
    logic [7:0]  aluop;
    logic [2:0]  alusel;
    logic [31:0] reg1;
    logic [31:0] reg2;
    logic [4:0]  wd;
    logic        wreg;
    logic        flush;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        whilo_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        ovf_o;
    logic        stallreq_o;

    int n_vec = 0;
    int n_mis = 0;

    ex_mdu #(.WIDTH(32), .REG_ADDR_W(5), .AOP_W(8), .ASEL_W(3)) dut (
        .clk        (clk),
        .rst        (rst),
        .aluop_i    (aluop),
        .alusel_i   (alusel),
        .reg1_i     (reg1),
        .reg2_i     (reg2),
        .wd_i       (wd),
        .wreg_i     (wreg),
        .flush_i    (flush),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .whilo_o    (whilo_o),
        .hi_o       (hi_o),
        .lo_o       (lo_o),
        .ovf_o      (ovf_o),
        .stallreq_o (stallreq_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                          input logic [31:0] a, input logic [31:0] b);
        aluop  = op;
        alusel = sel;
        reg1   = a;
        reg2   = b;
    endtask

    // Issue a divide held stable, count stall cycles, check the DONE cycle,
    // then drop to NOP and check HI/LO return to 0.
    task automatic run_div(input string tag, input logic [7:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input int exp_stall, input logic [31:0] exp_lo,
                           input logic [31:0] exp_hi);
        int ns;
        ns = 0;
        tick();
        set_op(op, EXE_RES_DIV, a, b);
        #3;
        while (stallreq_o === 1'b1 && ns < 40) begin
            ns++;
            tick();
            #3;
        end
        chk({tag, " stall cycles"}, 32'(ns), 32'(exp_stall));
        chk({tag, " whilo"}, {31'b0, whilo_o}, 32'd1);
        chk({tag, " lo"}, lo_o, exp_lo);
        chk({tag, " hi"}, hi_o, exp_hi);
        chk({tag, " wdata"}, wdata_o, 32'd0);
        tick();
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #3;
        chk({tag, " whilo after"}, {31'b0, whilo_o}, 32'd0);
        chk({tag, " lo after"}, lo_o, 32'd0);
        chk({tag, " stall after"}, {31'b0, stallreq_o}, 32'd0);
    endtask

    initial begin
        int pulses;

        // Reset: combinational outputs forced to 0 even with live inputs.
        rst   = 1'b0;
        flush = 1'b0;
        wd    = 5'd3;
        wreg  = 1'b1;
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000);
        tick();
        tick();
        #3;
        chk("rst wdata", wdata_o, 32'd0);
        chk("rst wd", {27'b0, wd_o}, 32'd0);
        chk("rst wreg", {31'b0, wreg_o}, 32'd0);
        set_op(EXE_DIV_OP, EXE_RES_DIV, 32'd10, 32'd2);
        #1;
        chk("rst stall", {31'b0, stallreq_o}, 32'd0);

        // OR
        tick();
        rst = 1'b1;
        set_op(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_F0F0, 32'h0F0F_0000);
        #3;
        chk("or wdata", wdata_o, 32'h0F0F_F0F0);
        chk("or wd", {27'b0, wd_o}, 32'd3);
        chk("or wreg", {31'b0, wreg_o}, 32'd1);
        chk("or stall", {31'b0, stallreq_o}, 32'd0);

        // ADD overflow
        tick();
        set_op(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1);
        #3;
        chk("add ovf", {31'b0, ovf_o}, 32'd1);
        chk("add wreg", {31'b0, wreg_o}, 32'd0);

        // ADDU same operands
        tick();
        set_op(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1);
        #3;
        chk("addu wdata", wdata_o, 32'h8000_0000);
        chk("addu ovf", {31'b0, ovf_o}, 32'd0);
        chk("addu wreg", {31'b0, wreg_o}, 32'd1);

        // SRA by 4, amount given as 36 (only low 5 bits count)
        tick();
        set_op(EXE_SRA_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'd36);
        #3;
        chk("sra wdata", wdata_o, 32'hF800_0000);

        tick();
        set_op(EXE_SRL_OP, EXE_RES_SHIFT, 32'h8000_0000, 32'd4);
        #3;
        chk("srl wdata", wdata_o, 32'h0800_0000);

        tick();
        set_op(EXE_SLL_OP, EXE_RES_SHIFT, 32'h0000_0001, 32'd31);
        #3;
        chk("sll wdata", wdata_o, 32'h8000_0000);

        // SUB overflow: most-negative minus 1
        tick();
        set_op(EXE_SUB_OP, EXE_RES_ARITH, 32'h8000_0000, 32'd1);
        #3;
        chk("sub ovf", {31'b0, ovf_o}, 32'd1);
        chk("sub wreg", {31'b0, wreg_o}, 32'd0);

        tick();
        set_op(EXE_SUBU_OP, EXE_RES_ARITH, 32'h8000_0000, 32'd1);
        #3;
        chk("subu wdata", wdata_o, 32'h7FFF_FFFF);
        chk("subu ovf", {31'b0, ovf_o}, 32'd0);

        tick();
        set_op(EXE_SLT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1);
        #3;
        chk("slt wdata", wdata_o, 32'd1);

        tick();
        set_op(EXE_SLTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'd1);
        #3;
        chk("sltu wdata", wdata_o, 32'd0);

        tick();
        set_op(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_00FF, 32'hFF00_0000);
        #3;
        chk("nor wdata", wdata_o, 32'h00FF_FF00);

        // Unknown alusel
        tick();
        set_op(EXE_ADD_OP, 3'b111, 32'h7FFF_FFFF, 32'd1);
        #3;
        chk("unk wdata", wdata_o, 32'd0);
        chk("unk ovf", {31'b0, ovf_o}, 32'd0);
        chk("unk whilo", {31'b0, whilo_o}, 32'd0);

        // Divides
        run_div("div -7/2", EXE_DIV_OP, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
        run_div("divu 100/7", EXE_DIVU_OP, 32'd100, 32'd7, 33, 32'd14, 32'd2);
        run_div("divu x/0", EXE_DIVU_OP, 32'd12345, 32'd0, 1, 32'd0, 32'd0);
        run_div("div min/-1", EXE_DIV_OP, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
        run_div("div 7/-2", EXE_DIV_OP, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
        run_div("divu max/1", EXE_DIVU_OP, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);

        // Flush at BUSY step 10
        tick();
        set_op(EXE_DIV_OP, EXE_RES_DIV, 32'd100, 32'd3);
        #3;
        for (int i = 0; i < 11; i++) tick();
        flush = 1'b1;
        #3;
        chk("flush stall", {31'b0, stallreq_o}, 32'd0);
        chk("flush whilo", {31'b0, whilo_o}, 32'd0);
        tick();
        flush = 1'b0;
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        pulses = 0;
        for (int i = 0; i < 30; i++) begin
            #3;
            if (whilo_o === 1'b1 || stallreq_o === 1'b1) pulses++;
            tick();
        end
        chk("flush idle after", 32'(pulses), 32'd0);
        run_div("divu 9/3 post flush", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0);

        // Reset mid-BUSY
        tick();
        wd   = 5'd7;
        wreg = 1'b1;
        set_op(EXE_DIV_OP, EXE_RES_DIV, 32'd1000, 32'd10);
        #3;
        for (int i = 0; i < 5; i++) tick();
        rst = 1'b0;
        #3;
        chk("midrst stall", {31'b0, stallreq_o}, 32'd0);
        chk("midrst whilo", {31'b0, whilo_o}, 32'd0);
        chk("midrst hi", hi_o, 32'd0);
        chk("midrst lo", lo_o, 32'd0);
        chk("midrst wd", {27'b0, wd_o}, 32'd0);
        chk("midrst wreg", {31'b0, wreg_o}, 32'd0);
        tick();
        rst = 1'b1;
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #3;
        chk("postrst stall", {31'b0, stallreq_o}, 32'd0);
        run_div("divu 9/3 post rst", EXE_DIVU_OP, 32'd9, 32'd3, 33, 32'd3, 32'd0);

        // Back-to-back DIVs held on the inputs: one whilo pulse each
        tick();
        set_op(EXE_DIV_OP, EXE_RES_DIV, 32'hFFFF_FFF9, 32'd2);
        pulses = 0;
        for (int i = 0; i < 68; i++) begin
            #3;
            if (whilo_o === 1'b1) begin
                pulses++;
                chk("b2b lo", lo_o, 32'hFFFF_FFFD);
            end
            tick();
        end
        set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
        #3;
        chk("b2b pulses", 32'(pulses), 32'd2);
        chk("b2b idle stall", {31'b0, stallreq_o}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
